// File: rtl/core_dmem_bus_adapter.sv
// core_dmem_bus_adapter: bridges the core's single-outstanding dmem port to the
// split-transaction data bus, absorbing abandoned requests and late responses.
module core_dmem_bus_adapter #(
    parameter int AW      = 64,
    parameter int DW      = 64,
    parameter int TIMEOUT = 255
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            c_req,
    input  logic [AW-1:0]   c_addr,
    input  logic            c_wen,
    input  logic [DW/8-1:0] c_strb,
    input  logic [DW-1:0]   c_wdata,
    output logic            c_gnt,
    output logic            c_err,
    output logic [DW-1:0]   c_rdata,
    output logic            m_req,
    output logic [AW-1:0]   m_addr,
    output logic            m_wen,
    output logic [DW/8-1:0] m_strb,
    output logic [DW-1:0]   m_wdata,
    input  logic            m_gnt,
    input  logic            m_rsp_valid,
    input  logic            m_rsp_err,
    input  logic [DW-1:0]   m_rsp_rdata,
    output logic            busy
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_RESP  = 3'd2;
    localparam logic [2:0] S_GNT   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    logic [2:0]      state_q, state_d;
    logic            abort_q, abort_d;
    logic            tout_q, tout_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            wen_q, wen_d;
    logic [DW/8-1:0] strb_q, strb_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            abort_now;
    // A core dropping c_req in this very cycle counts as abandoned already.
    assign abort_now = abort_q | ~c_req;
    always_comb begin
        state_d = state_q;
        abort_d = abort_q;
        tout_d  = tout_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        strb_d  = strb_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: if (c_req) begin
                addr_d  = c_addr;
                wen_d   = c_wen;
                strb_d  = c_strb;
                wdata_d = c_wdata;
                abort_d = 1'b0;
                state_d = S_ADDR;
            end
            S_ADDR: begin
                abort_d = abort_now;
                if (m_gnt) begin
                    cnt_d   = '0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                abort_d = abort_now;
                cnt_d   = cnt_q + CW'(1);
                if (m_rsp_valid) begin
                    if (!abort_now) begin
                        rdata_d = m_rsp_rdata;
                        err_d   = m_rsp_err;
                    end
                    state_d = abort_now ? S_IDLE : S_GNT;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    tout_d = 1'b1;
                    if (!abort_now) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                    state_d = abort_now ? S_DRAIN : S_GNT;
                end
            end
            S_GNT: state_d = tout_q ? S_DRAIN : S_IDLE;
            S_DRAIN: if (m_rsp_valid) begin
                tout_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q <= S_IDLE;
            abort_q <= 1'b0;
            tout_q  <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            strb_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            abort_q <= abort_d;
            tout_q  <= tout_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            strb_q  <= strb_d;
            wdata_q <= wdata_d;
        end
    end
    assign c_gnt   = state_q == S_GNT;
    assign m_req   = state_q == S_ADDR;
    assign busy    = state_q != S_IDLE;
    assign c_err   = err_q;
    assign c_rdata = rdata_q;
    assign m_addr  = addr_q;
    assign m_wen   = wen_q;
    assign m_strb  = strb_q;
    assign m_wdata = wdata_q;
endmodule

// File: tb/tb_core_dmem_bus_adapter.sv
// tb_core_dmem_bus_adapter: directed and random checks of the dmem bus adapter
// against a transaction-level model kept in the bench.
module tb_core_dmem_bus_adapter;
    localparam int TO = 4;
    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        c_req, c_wen, c_gnt, c_err;
    logic [63:0] c_addr, c_wdata, c_rdata;
    logic [7:0]  c_strb;
    logic        m_req, m_wen, m_gnt, m_rsp_valid, m_rsp_err, busy;
    logic [63:0] m_addr, m_wdata, m_rsp_rdata;
    logic [7:0]  m_strb;
    int vecs = 0;
    int errs = 0;

    core_dmem_bus_adapter #(.AW(64), .DW(64), .TIMEOUT(TO)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .c_req(c_req), .c_addr(c_addr), .c_wen(c_wen), .c_strb(c_strb), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_err(c_err), .c_rdata(c_rdata),
        .m_req(m_req), .m_addr(m_addr), .m_wen(m_wen), .m_strb(m_strb), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rsp_valid(m_rsp_valid), .m_rsp_err(m_rsp_err), .m_rsp_rdata(m_rsp_rdata),
        .busy(busy)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Inputs as the DUT saw them at the last rising edge.
    logic        s_rstn, s_req, s_wen, s_gnt, s_rv, s_rerr;
    logic [63:0] s_addr, s_wdata, s_rdata;
    logic [7:0]  s_strb;
    always @(posedge g_clk) begin
        s_rstn  <= g_resetn;
        s_req   <= c_req;
        s_addr  <= c_addr;
        s_wen   <= c_wen;
        s_strb  <= c_strb;
        s_wdata <= c_wdata;
        s_gnt   <= m_gnt;
        s_rv    <= m_rsp_valid;
        s_rerr  <= m_rsp_err;
        s_rdata <= m_rsp_rdata;
    end

    // Transaction-level model: which obligations are outstanding toward core and bus.
    bit          want_bus, await_rsp, owe_gnt, owe_drain, gave_up, timed_out;
    int          wait_n;
    logic [63:0] e_rdata, e_addr, e_wdata;
    logic        e_err, e_wen;
    logic [7:0]  e_strb;
    initial forever begin
        @(negedge g_clk);
        if (!s_rstn) begin
            {want_bus, await_rsp, owe_gnt, owe_drain, gave_up, timed_out} = '0;
            wait_n = 0;
            e_rdata = '0; e_err = 1'b0; e_addr = '0; e_wen = 1'b0; e_strb = '0; e_wdata = '0;
        end else if (!(want_bus || await_rsp || owe_gnt || owe_drain)) begin
            if (s_req) begin
                e_addr = s_addr; e_wen = s_wen; e_strb = s_strb; e_wdata = s_wdata;
                gave_up = 1'b0;
                want_bus = 1'b1;
            end
        end else if (want_bus) begin
            if (!s_req) gave_up = 1'b1;
            if (s_gnt) begin
                want_bus = 1'b0;
                await_rsp = 1'b1;
                wait_n = 0;
            end
        end else if (await_rsp) begin
            if (!s_req) gave_up = 1'b1;
            if (s_rv) begin
                await_rsp = 1'b0;
                if (!gave_up) begin
                    e_rdata = s_rdata; e_err = s_rerr; owe_gnt = 1'b1;
                end
            end else if (wait_n == TO - 1) begin
                await_rsp = 1'b0;
                timed_out = 1'b1;
                if (!gave_up) begin
                    e_rdata = '0; e_err = 1'b1; owe_gnt = 1'b1;
                end else owe_drain = 1'b1;
            end else wait_n++;
        end else if (owe_gnt) begin
            owe_gnt = 1'b0;
            if (timed_out) owe_drain = 1'b1;
        end else if (owe_drain && s_rv) begin
            owe_drain = 1'b0;
            timed_out = 1'b0;
        end
        chk("c_gnt",   64'(c_gnt),   64'(owe_gnt));
        chk("c_err",   64'(c_err),   64'(e_err));
        chk("c_rdata", c_rdata,      e_rdata);
        chk("m_req",   64'(m_req),   64'(want_bus));
        chk("m_addr",  m_addr,       e_addr);
        chk("m_wen",   64'(m_wen),   64'(e_wen));
        chk("m_strb",  64'(m_strb),  64'(e_strb));
        chk("m_wdata", m_wdata,      e_wdata);
        chk("busy",    64'(busy),    64'(want_bus || await_rsp || owe_gnt || owe_drain));
    end

    task automatic xfer(input logic [63:0] a, input logic [63:0] d, input logic e);
        c_req = 1'b1; c_addr = a; c_wen = 1'b0;
        @(negedge g_clk);
        chk("xf_mreq", 64'(m_req), 64'd1);
        chk("xf_maddr", m_addr, a);
        m_gnt = 1'b1;
        @(negedge g_clk);
        chk("xf_mreq_off", 64'(m_req), 64'd0);
        m_gnt = 1'b0; m_rsp_valid = 1'b1; m_rsp_rdata = d; m_rsp_err = e;
        @(negedge g_clk);
        chk("xf_gnt", 64'(c_gnt), 64'd1);
        m_rsp_valid = 1'b0; m_rsp_err = 1'b0; c_req = 1'b0;
        @(negedge g_clk);
        chk("xf_gnt_off", 64'(c_gnt), 64'd0);
        chk("xf_rdata", c_rdata, d);
        chk("xf_err", 64'(c_err), 64'(e));
        chk("xf_busy", 64'(busy), 64'd0);
    endtask

    bit          rsp_pend;
    int unsigned rsp_wait;
    initial begin
        g_resetn = 1'b0; c_req = 1'b0; c_addr = '0; c_wen = 1'b0; c_strb = '0; c_wdata = '0;
        m_gnt = 1'b0; m_rsp_valid = 1'b0; m_rsp_err = 1'b0; m_rsp_rdata = '0;
        repeat (2) @(negedge g_clk);
        chk("rst_mreq", 64'(m_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rdata", c_rdata, 64'd0);
        g_resetn = 1'b1;
        xfer(64'h1000, 64'hDEADBEEF_01234567, 1'b0);
        // write held off by the bus for five cycles; core inputs wander meanwhile
        c_req = 1'b1; c_wen = 1'b1; c_strb = 8'hF0; c_wdata = 64'hAAAA_AAAA_AAAA_AAAA; c_addr = 64'h2008;
        @(negedge g_clk);
        for (int i = 0; i < 6; i++) begin
            chk("bp_mreq", 64'(m_req), 64'd1);
            chk("bp_maddr", m_addr, 64'h2008);
            chk("bp_mstrb", 64'(m_strb), 64'hF0);
            chk("bp_mwdata", m_wdata, 64'hAAAA_AAAA_AAAA_AAAA);
            c_addr = 64'hBAD0; c_wdata = 64'h0; c_strb = 8'h0F;
            m_gnt = (i == 5);
            @(negedge g_clk);
        end
        m_gnt = 1'b0;
        @(negedge g_clk);
        m_rsp_valid = 1'b1; m_rsp_rdata = 64'h5555; m_rsp_err = 1'b0;
        @(negedge g_clk);
        chk("bp_gnt", 64'(c_gnt), 64'd1);
        m_rsp_valid = 1'b0; c_req = 1'b0; c_wen = 1'b0;
        @(negedge g_clk);
        chk("bp_busy", 64'(busy), 64'd0);
        xfer(64'h3000, 64'h1111, 1'b1);
        xfer(64'h3008, 64'h0123_4567_89AB_CDEF, 1'b0);
        // abandon during the response wait
        c_req = 1'b1; c_addr = 64'h4000;
        @(negedge g_clk);
        m_gnt = 1'b1;
        @(negedge g_clk);
        m_gnt = 1'b0; c_req = 1'b0;
        @(negedge g_clk);
        chk("ab_gnt", 64'(c_gnt), 64'd0);
        m_rsp_valid = 1'b1; m_rsp_rdata = 64'h7777;
        @(negedge g_clk);
        m_rsp_valid = 1'b0;
        chk("ab_gnt2", 64'(c_gnt), 64'd0);
        chk("ab_busy", 64'(busy), 64'd0);
        chk("ab_rdata", c_rdata, 64'h0123_4567_89AB_CDEF);
        // bus never answers in time
        c_req = 1'b1; c_addr = 64'h5000;
        @(negedge g_clk);
        m_gnt = 1'b1;
        @(negedge g_clk);
        m_gnt = 1'b0;
        repeat (4) begin
            chk("to_nogs", 64'(c_gnt), 64'd0);
            @(negedge g_clk);
        end
        chk("to_gnt", 64'(c_gnt), 64'd1);
        chk("to_err", 64'(c_err), 64'd1);
        chk("to_rdata", c_rdata, 64'd0);
        c_req = 1'b0;
        @(negedge g_clk);
        c_req = 1'b1; c_addr = 64'h6000;
        repeat (9) begin
            chk("dr_mreq", 64'(m_req), 64'd0);
            chk("dr_busy", 64'(busy), 64'd1);
            @(negedge g_clk);
        end
        m_rsp_valid = 1'b1; m_rsp_rdata = 64'hFFFF;
        @(negedge g_clk);
        m_rsp_valid = 1'b0;
        chk("dr_idle", 64'(busy), 64'd0);
        chk("dr_keep", c_rdata, 64'd0);
        @(negedge g_clk);
        chk("dr_newreq", 64'(m_req), 64'd1);
        chk("dr_newaddr", m_addr, 64'h6000);
        g_resetn = 1'b0;
        @(negedge g_clk);
        chk("rs_mreq", 64'(m_req), 64'd0);
        chk("rs_busy", 64'(busy), 64'd0);
        chk("rs_gnt", 64'(c_gnt), 64'd0);
        chk("rs_rdata", c_rdata, 64'd0);
        chk("rs_err", 64'(c_err), 64'd0);
        g_resetn = 1'b1; c_req = 1'b0;
        rsp_pend = 1'b0;
        rsp_wait = 0;
        repeat (3000) begin
            @(negedge g_clk);
            if (c_req && c_gnt) c_req = 1'b0;
            else if (c_req && $urandom_range(0, 49) == 0) c_req = 1'b0;
            else if (!c_req && $urandom_range(0, 2) == 0) begin
                c_req = 1'b1;
                c_addr = {$urandom, $urandom} & ~64'h7;
                c_wen = 1'($urandom);
                c_strb = 8'($urandom);
                c_wdata = {$urandom, $urandom};
            end
            if (rsp_pend) begin
                if (rsp_wait == 0) begin
                    m_rsp_valid = 1'b1;
                    rsp_pend = 1'b0;
                end else begin
                    m_rsp_valid = 1'b0;
                    rsp_wait--;
                end
            end else m_rsp_valid = ($urandom_range(0, 19) == 0);
            m_rsp_err = ($urandom_range(0, 4) == 0);
            m_rsp_rdata = {$urandom, $urandom};
            m_gnt = 1'($urandom);
            if (m_req && m_gnt) begin
                rsp_pend = 1'b1;
                rsp_wait = $urandom_range(0, 12);
            end
        end
        @(negedge g_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/core_dmem_bus_adapter.md
Name: core_dmem_bus_adapter

Overview:
Sits directly downstream of the execute-stage LSU. Bridges the core's single-outstanding dmem interface to the split-transaction system data bus. The core side uses dmem_req/gnt, with rdata/err sampled the cycle after gnt. The bus side uses an address phase (req/gnt) and a separate, variable-latency response phase (rsp_valid). The block also handles abandoned core requests and bus response timeouts.

Parameters:
AW, 64, address width
DW, 64, data width (strobe width DW/8)
TIMEOUT, 255, max cycles waiting for bus response; 0 disables timeout

Ports:
g_clk  in  1  global clock
g_resetn  in  1  synchronous active-low reset
c_req  in  1  core memory request
c_addr  in  AW  core address (doubleword aligned)
c_wen  in  1  core write enable
c_strb  in  DW/8  core write strobe
c_wdata  in  DW  core write data
c_gnt  out  1  core grant, one-cycle pulse
c_err  out  1  response error, valid cycle after c_gnt
c_rdata  out  DW  response read data, valid cycle after c_gnt
m_req  out  1  bus address-phase request
m_addr  out  AW  bus address
m_wen  out  1  bus write enable
m_strb  out  DW/8  bus strobe
m_wdata  out  DW  bus write data
m_gnt  in  1  bus address-phase accept
m_rsp_valid  in  1  bus response valid
m_rsp_err  in  1  bus response error
m_rsp_rdata  in  DW  bus response data
busy  out  1  state != IDLE

Behaviour:
- Reset (sync, active-low) values: state IDLE; c_gnt, c_err, m_req, abort and tout flags = 0; c_rdata = 0; m_addr/m_wen/m_strb/m_wdata = 0.
- States: IDLE, ADDR, RESP, GNT, DRAIN.
- IDLE:
  - If c_req=1, latch c_addr/c_wen/c_strb/c_wdata into the m_* registers, clear abort, go to ADDR.
- ADDR:
  - m_req=1.
  - m_* held stable until m_gnt. Bus rule: once asserted, m_req is never withdrawn.
  - If m_gnt=1, go to RESP and clear the timeout counter.
- RESP:
  - m_req=0. Counter increments each cycle.
  - If m_rsp_valid=1: capture m_rsp_rdata into c_rdata and m_rsp_err into c_err.
    - If abort=1, go to IDLE.
    - Otherwise go to GNT.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1:
    - c_rdata<=0, c_err<=1, tout<=1.
    - If abort=1, go to DRAIN. Otherwise go to GNT.
  - A response arriving in the same cycle as the timeout wins: no timeout is taken.
- GNT:
  - c_gnt=1 for exactly one cycle.
  - If tout=1, go to DRAIN. Otherwise go to IDLE.
- DRAIN:
  - Wait for the late m_rsp_valid, discard it, clear tout, go to IDLE.
  - c_rdata/c_err are not modified.
  - No new request is accepted in DRAIN. The bus never responding here is a deadlock by design.
- Abort:
  - In ADDR or RESP, if c_req=0 in any cycle, set abort.
  - The bus transaction still completes; no c_gnt is issued and c_rdata/c_err are not updated.
  - Abort is sticky until IDLE.
- c_rdata/c_err are registers. They are updated only on capture and held until the next capture, so they are stable on the cycle after c_gnt.
- Minimum latency, c_req in cycle 0 with m_gnt in cycle 1:
  - m_rsp_valid earliest in cycle 2.
  - c_gnt in cycle 3.
  - Data/err valid in cycle 4.
- Writes follow the identical flow. c_rdata is captured as returned (don't-care for the core).
- m_rsp_valid outside RESP/DRAIN is ignored.
- c_gnt is never asserted while c_req=0 in the preceding cycle (abort guarantee).
- Reset mid-transaction returns to IDLE immediately. The outstanding bus response is not tracked; the system resets the bus with the core.

Test Plan:
- Read, zero-wait bus: c_req at cyc0 with c_addr=0x1000; m_gnt at cyc1; m_rsp_valid at cyc2 with rdata=0xDEADBEEF_01234567 -> m_req high cyc1 only, c_gnt pulse cyc3, c_rdata=0xDEADBEEF_01234567 and c_err=0 at cyc4.
- Write with backpressure: c_wen=1, c_strb=0xF0, c_wdata=0xAA...; m_gnt withheld 5 cycles -> m_req held with m_addr/m_strb/m_wdata unchanged for 6 cycles; c_gnt issued after the response.
- Bus error: m_rsp_err=1 -> c_err=1 on the cycle after c_gnt; c_err returns to 0 after a later clean read.
- Abort: c_req dropped during RESP -> response absorbed, c_gnt never asserted, c_rdata unchanged, busy=0 the cycle after the response.
- Timeout, TIMEOUT=4: no response -> c_gnt 4 cycles after entering RESP, c_err=1, c_rdata=0; a late response 10 cycles later is drained; a new c_req is not accepted (m_req=0) until the drain completes.
- Reset during ADDR -> next cycle m_req=0, busy=0, c_gnt=0, c_rdata=0.
